// File: rtl/cpu_debug_pkg.sv
// cpu_debug_pkg: shared constants and types for the
// sysclk-side JTAG debug command path.
package cpu_debug_pkg;

  localparam int unsigned IR_OCIMEM    = 0;
  localparam int unsigned IR_TRACECTRL = 1;
  localparam int unsigned IR_BREAK     = 2;
  localparam int unsigned IR_TRACEMEM  = 3;

  localparam int unsigned SR_W_DEF       = 38;
  localparam int unsigned ACTION_BIT_DEF = 35;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

endpackage

// File: rtl/cpu_debug_strobe_sync.sv
// cpu_debug_strobe_sync: multi-flop synchroniser followed
// by a registered rising-edge detector.
module cpu_debug_strobe_sync #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], strobe};
      prev_q <= sync_q[STAGES-1];
      pulse  <= sync_q[STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/cpu_debug_cmd_queue.sv
// cpu_debug_cmd_queue: syncs debug update strobes, queues
// {ir, sr} scans in a FIFO and decodes each popped command.
module cpu_debug_cmd_queue
  import cpu_debug_pkg::*;
#(
  parameter int unsigned IR_W        = 2,
  parameter int unsigned SR_W        = SR_W_DEF,
  parameter int unsigned ACTION_BIT  = ACTION_BIT_DEF,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   vs_udr,
  input  logic                   vs_uir,
  input  logic [IR_W-1:0]        ir_in,
  input  logic [SR_W-1:0]        sr,
  input  logic                   cmd_ready,
  output logic                   cmd_valid,
  output logic [IR_W-1:0]        cmd_ir,
  output logic [SR_W-1:0]        jdo,
  output logic [2**IR_W-1:0]     take_action,
  output logic [2**IR_W-1:0]     take_no_action,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   overflow_clr
);

  localparam int unsigned NI = 2**IR_W;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic            uir_p;
  logic            udr_p;
  logic [IR_W-1:0] ir_hold;
  logic [IR_W-1:0] mem_ir [DEPTH];
  logic [SR_W-1:0] mem_sr [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   level_nxt;
  logic [SR_W-1:0] head_sr;
  logic [NI-1:0]   head_oh;
  logic            full;
  logic            pop;
  logic            push;
  logic            ovf_set;
  occ_e            occ_q;
  occ_e            occ_nxt;

  cpu_debug_strobe_sync #(
    .STAGES (SYNC_STAGES)
  ) u_uir_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (vs_uir),
    .pulse   (uir_p)
  );

  cpu_debug_strobe_sync #(
    .STAGES (SYNC_STAGES)
  ) u_udr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (vs_udr),
    .pulse   (udr_p)
  );

  assign cmd_ir    = mem_ir[rd_ptr];
  assign head_sr   = mem_sr[rd_ptr];
  assign head_oh   = NI'(1) << cmd_ir;
  assign cmd_valid = (occ_q != OCC_EMPTY);
  assign full      = (occ_q == OCC_FULL);
  assign pop       = cmd_valid & cmd_ready;
  // A pop in the same cycle frees the slot for a push at full.
  assign push      = udr_p & (~full | pop);
  assign ovf_set   = udr_p & full & ~pop;
  assign level_nxt = level + LW'(push) - LW'(pop);

  always_comb begin
    occ_nxt = OCC_PARTIAL;
    unique case (1'b1)
      (level_nxt == '0):         occ_nxt = OCC_EMPTY;
      (level_nxt == LW'(DEPTH)): occ_nxt = OCC_FULL;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= OCC_EMPTY;
      level <= '0;
    end else begin
      occ_q <= occ_nxt;
      level <= level_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_hold <= '0;
    end else if (uir_p) begin
      ir_hold <= ir_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_ir[i] <= '0;
        mem_sr[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_ir[wr_ptr] <= ir_hold;
        mem_sr[wr_ptr] <= sr;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else if (pop) begin
      jdo            <= head_sr;
      take_action    <= head_sr[ACTION_BIT] ? head_oh : '0;
      take_no_action <= head_sr[ACTION_BIT] ? '0 : head_oh;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_debug_cmd_queue.sv
// tb_cpu_debug_cmd_queue: randomized bench with a queue-based
// reference model plus directed literal checks.
module tb_cpu_debug_cmd_queue;

  localparam int SS    = 3;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]  ir;
    logic [37:0] sr;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vs_udr;
  logic        vs_uir;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        man_rdy;
  logic        rnd_rdy;
  logic        man_clr;
  logic        rnd_clr;
  logic        rnd_en;
  wire         cmd_ready    = rnd_en ? rnd_rdy : man_rdy;
  wire         overflow_clr = rnd_en ? rnd_clr : man_clr;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] jdo;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic [2:0]  level;
  logic        overflow;

  logic        p_udr;
  logic        p_uir;
  logic [2:0]  p_ir_in;
  logic [37:0] p_sr;
  logic        p_rdy;
  logic        p_clr;
  logic        p_valid;
  logic [2:0]  p_cmd_ir;
  logic [37:0] p_jdo;
  logic [7:0]  p_ta;
  logic [7:0]  p_tna;
  logic [1:0]  p_level;
  logic        p_ov;

  int tests  = 0;
  int fails  = 0;
  int rdy_div = 2;
  bit chk_en = 1'b0;

  cmd_t        m_q[$];
  logic [SS+1:0] hu;
  logic [SS+1:0] hr;
  logic [1:0]  m_hold;
  logic [37:0] m_jdo;
  logic [3:0]  m_ta;
  logic [3:0]  m_tna;
  logic        m_ov;

  always #5 clk = ~clk;

  cpu_debug_cmd_queue dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .level          (level),
    .overflow       (overflow),
    .overflow_clr   (overflow_clr)
  );

  cpu_debug_cmd_queue #(
    .IR_W        (3),
    .DEPTH       (2),
    .SYNC_STAGES (2)
  ) dut_p (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_udr         (p_udr),
    .vs_uir         (p_uir),
    .ir_in          (p_ir_in),
    .sr             (p_sr),
    .cmd_ready      (p_rdy),
    .cmd_valid      (p_valid),
    .cmd_ir         (p_cmd_ir),
    .jdo            (p_jdo),
    .take_action    (p_ta),
    .take_no_action (p_tna),
    .level          (p_level),
    .overflow       (p_ov),
    .overflow_clr   (p_clr)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_ir(input logic [1:0] ir);
    ir_in  = ir;
    vs_uir = 1'b1;
    cyc(2);
    vs_uir = 1'b0;
    cyc(SS + 3);
  endtask

  task automatic send_dr(input logic [37:0] d);
    sr     = d;
    vs_udr = 1'b1;
    cyc(SS + 2);
    vs_udr = 1'b0;
    cyc(2);
  endtask

  task automatic send_cmd(input logic [1:0] ir,
                          input logic [37:0] d);
    send_ir(ir);
    send_dr(d);
  endtask

  task automatic p_send(input logic [37:0] d);
    p_sr  = d;
    p_udr = 1'b1;
    cyc(4);
    p_udr = 1'b0;
    cyc(2);
  endtask

  // Reference model: strobe edges are found in the sampled
  // input history SS+1 edges back; FIFO is a plain queue.
  initial begin
    cmd_t c;
    bit   do_push, do_lat, do_pop, ovf;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_q.delete();
        hu     = '0;
        hr     = '0;
        m_hold = '0;
        m_jdo  = '0;
        m_ta   = '0;
        m_tna  = '0;
        m_ov   = 1'b0;
      end else begin
        do_push = hu[SS] & ~hu[SS+1];
        do_lat  = hr[SS] & ~hr[SS+1];
        do_pop  = (m_q.size() != 0) && cmd_ready;
        ovf     = 1'b0;
        m_ta    = '0;
        m_tna   = '0;
        if (do_pop) begin
          c     = m_q.pop_front();
          m_jdo = c.sr;
          if (c.sr[35]) m_ta = 4'b0001 << c.ir;
          else          m_tna = 4'b0001 << c.ir;
        end
        if (do_push) begin
          if (m_q.size() < DEPTH) begin
            c.ir = m_hold;
            c.sr = sr;
            m_q.push_back(c);
          end else begin
            ovf = 1'b1;
          end
        end
        if (ovf) m_ov = 1'b1;
        else if (overflow_clr) m_ov = 1'b0;
        if (do_lat) m_hold = ir_in;
        hu = {hu[SS:0], vs_udr};
        hr = {hr[SS:0], vs_uir};
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("valid", 64'(cmd_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0)
          chk("cmd_ir", 64'(cmd_ir), 64'(m_q[0].ir));
        chk("jdo", 64'(jdo), 64'(m_jdo));
        chk("take_action", 64'(take_action), 64'(m_ta));
        chk("take_no_action", 64'(take_no_action),
            64'(m_tna));
        chk("level", 64'(level), 64'(m_q.size()));
        chk("overflow", 64'(overflow), 64'(m_ov));
      end
    end
  end

  initial begin
    rnd_rdy = 1'b0;
    rnd_clr = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      rnd_rdy = ($urandom_range(rdy_div - 1, 0) == 0);
      rnd_clr = ($urandom_range(15, 0) == 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    vs_udr  = 1'b0;
    vs_uir  = 1'b0;
    ir_in   = '0;
    sr      = '0;
    man_rdy = 1'b0;
    man_clr = 1'b0;
    rnd_en  = 1'b0;
    p_udr   = 1'b0;
    p_uir   = 1'b0;
    p_ir_in = '0;
    p_sr    = '0;
    p_rdy   = 1'b0;
    p_clr   = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    chk("rst_valid", 64'(cmd_valid), 0);
    chk("rst_cmd_ir", 64'(cmd_ir), 0);
    chk("rst_jdo", 64'(jdo), 0);
    chk("rst_level", 64'(level), 0);
    chk("rst_overflow", 64'(overflow), 0);

    // Single action command, latency from first high sample.
    send_ir(2'd2);
    sr     = 38'h08_0000_1234;
    vs_udr = 1'b1;
    cyc(4);
    chk("lat_pre", 64'(cmd_valid), 0);
    cyc(1);
    chk("lat_post", 64'(cmd_valid), 1);
    chk("head_ir", 64'(cmd_ir), 2);
    cyc(1);
    vs_udr = 1'b0;
    cyc(2);
    man_rdy = 1'b1;
    cyc(1);
    man_rdy = 1'b0;
    chk("act_vec", 64'(take_action), 64'b0100);
    chk("act_nvec", 64'(take_no_action), 0);
    chk("act_jdo", 64'(jdo), 64'h08_0000_1234);
    cyc(1);
    chk("act_pulse_end", 64'(take_action), 0);

    // No-action path.
    send_cmd(2'd0, 38'h01_2345_6789);
    man_rdy = 1'b1;
    cyc(1);
    man_rdy = 1'b0;
    chk("nact_vec", 64'(take_no_action), 64'b0001);
    chk("nact_avec", 64'(take_action), 0);
    chk("nact_jdo", 64'(jdo), 64'h01_2345_6789);

    // Five pushes into a depth-4 FIFO.
    for (int i = 0; i < 5; i++)
      send_cmd(2'(i), 38'h0A_0000_0000 + 38'(i));
    chk("ovf_level", 64'(level), 4);
    chk("ovf_flag", 64'(overflow), 1);
    chk("ovf_head", 64'(cmd_ir), 0);
    man_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("ovf_order", 64'(jdo), 64'h0A_0000_0000 + 64'(i));
    end
    man_rdy = 1'b0;
    chk("ovf_drained", 64'(level), 0);
    man_clr = 1'b1;
    cyc(1);
    man_clr = 1'b0;
    chk("ovf_clr", 64'(overflow), 0);

    // Push and pop in the same cycle at full.
    for (int i = 0; i < 4; i++)
      send_cmd(2'(3 - i), 38'h00_0000_0100 + 38'(i));
    send_ir(2'd3);
    sr     = 38'h0F_0000_0555;
    vs_udr = 1'b1;
    cyc(SS + 1);
    man_rdy = 1'b1;
    cyc(1);
    man_rdy = 1'b0;
    chk("pp_level", 64'(level), 4);
    chk("pp_overflow", 64'(overflow), 0);
    vs_udr = 1'b0;
    cyc(2);
    man_rdy = 1'b1;
    cyc(5);
    man_rdy = 1'b0;

    // Reset mid-burst with two queued entries.
    send_cmd(2'd1, 38'h3F_FFFF_FFFF);
    send_cmd(2'd2, 38'h00_0000_0001);
    chk("burst_level", 64'(level), 2);
    reset_n = 1'b0;
    cyc(3);
    chk("mid_valid", 64'(cmd_valid), 0);
    chk("mid_level", 64'(level), 0);
    chk("mid_jdo", 64'(jdo), 0);
    chk("mid_ta", 64'(take_action | take_no_action), 0);
    reset_n = 1'b1;
    cyc(8);
    chk("quiet_level", 64'(level), 0);

    // Strobe already high when reset releases.
    reset_n = 1'b0;
    sr      = 38'h08_ABCD_0000;
    vs_udr  = 1'b1;
    cyc(2);
    reset_n = 1'b1;
    cyc(SS + 3);
    chk("rel_level", 64'(level), 1);
    chk("rel_ir", 64'(cmd_ir), 0);
    vs_udr = 1'b0;
    cyc(4);
    chk("rel_single", 64'(level), 1);
    man_rdy = 1'b1;
    cyc(2);
    man_rdy = 1'b0;

    // Randomized traffic: slow drain, then fast drain.
    rnd_en = 1'b1;
    for (int ph = 0; ph < 2; ph++) begin
      rdy_div = (ph == 0) ? 16 : 2;
      for (int i = 0; i < 30; i++)
        send_cmd(2'($urandom_range(3, 0)),
                 38'({$urandom, $urandom}));
    end
    rnd_en  = 1'b0;
    man_rdy = 1'b1;
    cyc(8);
    man_rdy = 1'b0;
    chk("rand_drained", 64'(level), 0);

    // Parametric instance: IR_W=3, DEPTH=2, SYNC_STAGES=2.
    p_ir_in = 3'd5;
    p_uir   = 1'b1;
    cyc(2);
    p_uir = 1'b0;
    cyc(5);
    p_sr  = 38'h08_0000_00AB;
    p_udr = 1'b1;
    cyc(3);
    chk("p_lat_pre", 64'(p_valid), 0);
    cyc(1);
    chk("p_lat_post", 64'(p_valid), 1);
    chk("p_head_ir", 64'(p_cmd_ir), 5);
    p_udr = 1'b0;
    cyc(2);
    p_rdy = 1'b1;
    cyc(1);
    p_rdy = 1'b0;
    chk("p_act", 64'(p_ta), 64'h20);
    chk("p_nact", 64'(p_tna), 0);
    chk("p_jdo", 64'(p_jdo), 64'h08_0000_00AB);
    p_send(38'h1);
    p_send(38'h2);
    chk("p_full_no_ovf", 64'(p_ov), 0);
    p_send(38'h3);
    chk("p_level", 64'(p_level), 2);
    chk("p_overflow", 64'(p_ov), 1);

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
